// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with PSR flags and optional shift-add MUL.
// Optional multiplier under `ALU_MUL_EN. Ports: clk, reset_n, in_valid/in_ready,
// alu_cont, a, b -> alu_out, out_valid; psr_load/psr_in -> psr_flags.
module alu_seq #(
  parameter int WIDTH         = 16,
  parameter int ALU_CONT_BITS = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ALU_CONT_BITS-1:0] alu_cont,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic [WIDTH-1:0]         alu_out,
  output logic                     out_valid,
  input  logic                     psr_load,
  input  logic [15:0]              psr_in,
  output logic [15:0]              psr_flags
);

  localparam int SW = $clog2(WIDTH);
  localparam int HW = WIDTH / 2;
  localparam int M  = WIDTH - 1;

  typedef logic [ALU_CONT_BITS-1:0] op_t;
  localparam op_t OP_AND  = op_t'(0);
  localparam op_t OP_OR   = op_t'(1);
  localparam op_t OP_XOR  = op_t'(2);
  localparam op_t OP_ADD  = op_t'(3);
  localparam op_t OP_SUB  = op_t'(4);
  localparam op_t OP_CMP  = op_t'(5);
  localparam op_t OP_MOV  = op_t'(6);
  localparam op_t OP_LSH  = op_t'(7);
  localparam op_t OP_LUI  = op_t'(8);
  localparam op_t OP_PASA = op_t'(9);
  localparam op_t OP_INC  = op_t'(10);
  localparam op_t OP_ADDU = op_t'(11);
  localparam op_t OP_ASHR = op_t'(13);

`ifdef ALU_MUL_EN
  localparam op_t OP_MUL = op_t'(12);
  localparam int  CW     = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_DONE, S_MUL} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

  state_t state_q, state_d;
  logic accept;
  logic [WIDTH-1:0] res;
  logic res_we;
  logic n_q, z_q, f_q, l_q, c_q;
  logic n_d, z_d, f_d, l_d, c_d;
  logic n_we, z_we, f_we, l_we, c_we;
  logic [WIDTH:0] add_w;
  logic [WIDTH-1:0] sub_w, nb, lsh_w, asr_w;
  logic unused_psr;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod_q, prod_d, mul_step;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] mul_sum;

  // Add multiplicand into the high half when the low bit is set, then shift.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_step = {mul_sum, prod_q[WIDTH-1:1]};
  assign in_ready = (state_q != S_MUL);
`else
  assign in_ready = 1'b1;
`endif

  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign psr_flags = {8'b0, n_q, z_q, f_q, 2'b00, l_q, 1'b0, c_q};
  assign unused_psr = ^{psr_in[15:8], psr_in[4:3], psr_in[1]};

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = a - b;
  assign nb    = '0 - b;
  assign asr_w = $unsigned($signed(a) >>> b[SW-1:0]);

  // b is a signed amount: non-negative shifts left, negative shifts right.
  always_comb begin
    lsh_w = '0;
    if (!b[M]) begin
      if (b < WIDTH'(WIDTH)) lsh_w = a << b;
    end else if (nb < WIDTH'(WIDTH)) begin
      lsh_w = a >> nb;
    end
  end

  always_comb begin
    state_d = state_q;
    res     = '0;
    res_we  = 1'b0;
    n_we = 1'b0; z_we = 1'b0; f_we = 1'b0;
    l_we = 1'b0; c_we = 1'b0;
    n_d = 1'b0; z_d = 1'b0; f_d = 1'b0;
    l_d = 1'b0; c_d = 1'b0;
`ifdef ALU_MUL_EN
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_DONE;
          res_we  = 1'b1;
          case (alu_cont)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_ADD: begin
              res  = add_w[M:0];
              c_we = 1'b1;
              c_d  = add_w[WIDTH];
              f_we = 1'b1;
              f_d  = (a[M] == b[M]) && (add_w[M] != a[M]);
            end
            OP_ADDU: res = add_w[M:0];
            OP_SUB: begin
              res  = sub_w;
              c_we = 1'b1;
              c_d  = (a < b);
              f_we = 1'b1;
              f_d  = (a[M] != b[M]) && (sub_w[M] != a[M]);
            end
            OP_CMP: begin
              res_we = 1'b0;
              z_we = 1'b1;
              z_d  = (a == b);
              n_we = 1'b1;
              n_d  = ($signed(a) < $signed(b));
              l_we = 1'b1;
              l_d  = (a < b);
            end
            OP_MOV:  res = b;
            OP_LSH:  res = lsh_w;
            OP_LUI:  res = b << HW;
            OP_PASA: res = a;
            OP_INC:  res = a + WIDTH'(1);
            OP_ASHR: res = asr_w;
`ifdef ALU_MUL_EN
            OP_MUL: begin
              res_we  = 1'b0;
              state_d = S_MUL;
              prod_d  = {{WIDTH{1'b0}}, b};
              mcand_d = a;
              cnt_d   = '0;
            end
`endif
            default: res = '0;
          endcase
        end
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        prod_d = mul_step;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          res_we  = 1'b1;
          res     = mul_step[M:0];
          c_we = 1'b1;
          f_we = 1'b1;
          c_d  = |mul_step[2*WIDTH-1:WIDTH];
          f_d  = |mul_step[2*WIDTH-1:WIDTH];
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      alu_out <= '0;
      n_q <= 1'b0; z_q <= 1'b0; f_q <= 1'b0;
      l_q <= 1'b0; c_q <= 1'b0;
`ifdef ALU_MUL_EN
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (res_we) alu_out <= res;
      // A software restore overrides any same-cycle flag update.
      if (psr_load) begin
        n_q <= psr_in[7];
        z_q <= psr_in[6];
        f_q <= psr_in[5];
        l_q <= psr_in[2];
        c_q <= psr_in[0];
      end else begin
        if (n_we) n_q <= n_d;
        if (z_we) z_q <= z_d;
        if (f_we) f_q <= f_d;
        if (l_we) l_q <= l_d;
        if (c_we) c_q <= c_d;
      end
`ifdef ALU_MUL_EN
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq.
// Both builds of the multiplier option are covered.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alu_cont;
  logic [15:0] a, b;
  logic [15:0] alu_out;
  logic        out_valid;
  logic        psr_load;
  logic [15:0] psr_in;
  logic [15:0] psr_flags;

  int vectors = 0;
  int miscompares = 0;

  alu_seq #(.WIDTH(16), .ALU_CONT_BITS(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_cont(alu_cont), .a(a), .b(b),
    .alu_out(alu_out), .out_valid(out_valid),
    .psr_load(psr_load), .psr_in(psr_in),
    .psr_flags(psr_flags)
  );

  always #5 clk = ~clk;

  // Present one request for one cycle; returns at the negedge after accept.
  task automatic issue(input logic [4:0] op,
                       input logic [15:0] va,
                       input logic [15:0] vb);
    @(negedge clk);
    in_valid = 1'b1; alu_cont = op; a = va; b = vb;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_valid = 1'b0; alu_cont = '0;
    a = '0; b = '0; psr_load = 1'b0; psr_in = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (alu_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL rst_alu_out got %h want 0000", alu_out);
    end
    vectors++;
    if (psr_flags !== 16'h0000) begin
      miscompares++;
      $display("FAIL rst_psr got %h want 0000", psr_flags);
    end
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_hs got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_add;
    issue(5'b00011, 16'h7FFF, 16'h0001);
    vectors++;
    if (alu_out !== 16'h8000 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL add_ovf got %h v=%b want 8000 v=1", alu_out, out_valid);
    end
    vectors++;
    if (psr_flags !== 16'h0020) begin
      miscompares++;
      $display("FAIL add_ovf_psr got %h want 0020", psr_flags);
    end
    issue(5'b00011, 16'hFFFF, 16'h0001);
    vectors++;
    if (alu_out !== 16'h0000 || psr_flags !== 16'h0001) begin
      miscompares++;
      $display("FAIL add_carry got %h psr %h want 0000 psr 0001", alu_out, psr_flags);
    end
  endtask

  task automatic test_sub;
    issue(5'b00100, 16'h0000, 16'h0001);
    vectors++;
    if (alu_out !== 16'hFFFF || psr_flags !== 16'h0001) begin
      miscompares++;
      $display("FAIL sub_borrow got %h psr %h want ffff psr 0001", alu_out, psr_flags);
    end
    issue(5'b00100, 16'h8000, 16'h0001);
    vectors++;
    if (alu_out !== 16'h7FFF || psr_flags !== 16'h0020) begin
      miscompares++;
      $display("FAIL sub_ovf got %h psr %h want 7fff psr 0020", alu_out, psr_flags);
    end
  endtask

  task automatic test_cmp;
    issue(5'b00101, 16'h8000, 16'h0001);
    vectors++;
    if (alu_out !== 16'h7FFF || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL cmp_hold got %h v=%b want 7fff v=1", alu_out, out_valid);
    end
    vectors++;
    if (psr_flags !== 16'h00A0) begin
      miscompares++;
      $display("FAIL cmp_lt_psr got %h want 00a0", psr_flags);
    end
    issue(5'b00101, 16'h1234, 16'h1234);
    vectors++;
    if (psr_flags !== 16'h0060) begin
      miscompares++;
      $display("FAIL cmp_eq_psr got %h want 0060", psr_flags);
    end
  endtask

  task automatic test_shift;
    logic [4:0]  op [5] = '{5'b00111, 5'b00111, 5'b00111, 5'b00111, 5'b01101};
    logic [15:0] va [5] = '{16'h0003, 16'h0003, 16'h0003, 16'h0003, 16'h8000};
    logic [15:0] vb [5] = '{16'h0004, 16'hFFFF, 16'h0010, 16'hFFF0, 16'h0003};
    logic [15:0] ex [5] = '{16'h0030, 16'h0001, 16'h0000, 16'h0000, 16'hF000};
    for (int i = 0; i < 5; i++) begin
      issue(op[i], va[i], vb[i]);
      vectors++;
      if (alu_out !== ex[i] || psr_flags !== 16'h0060) begin
        miscompares++;
        $display("FAIL shift_%0d got %h psr %h want %h psr 0060", i, alu_out, psr_flags, ex[i]);
      end
    end
  endtask

  task automatic test_misc_ops;
    logic [4:0]  op [9] = '{5'b00000, 5'b00001, 5'b00010, 5'b00110, 5'b01000,
                            5'b01001, 5'b01010, 5'b01011, 5'b11111};
    logic [15:0] va [9] = '{16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h1111, 16'h1111,
                            16'hBEEF, 16'hFFFF, 16'hFFFF, 16'h1234};
    logic [15:0] vb [9] = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hCAFE, 16'h0012,
                            16'h2222, 16'h0000, 16'h0002, 16'h5678};
    logic [15:0] ex [9] = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'hCAFE, 16'h1200,
                            16'hBEEF, 16'h0000, 16'h0001, 16'h0000};
    for (int i = 0; i < 9; i++) begin
      issue(op[i], va[i], vb[i]);
      vectors++;
      if (alu_out !== ex[i] || out_valid !== 1'b1 || psr_flags !== 16'h0060) begin
        miscompares++;
        $display("FAIL op_%0d got %h v=%b psr %h want %h v=1 psr 0060",
                 i, alu_out, out_valid, psr_flags, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    in_valid = 1'b1; alu_cont = 5'b00011; a = 16'h0001; b = 16'h0002;
    @(negedge clk);
    vectors++;
    if (alu_out !== 16'h0003 || out_valid !== 1'b1 || psr_flags !== 16'h0040) begin
      miscompares++;
      $display("FAIL b2b_0 got %h v=%b psr %h want 0003 v=1 psr 0040", alu_out, out_valid, psr_flags);
    end
    alu_cont = 5'b00010; a = 16'hAAAA; b = 16'h5555;
    @(negedge clk);
    vectors++;
    if (alu_out !== 16'hFFFF || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_1 got %h v=%b r=%b want ffff v=1 r=1", alu_out, out_valid, in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (alu_out !== 16'hFFFF || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle got %h v=%b want ffff v=0", alu_out, out_valid);
    end
  endtask

  task automatic test_psr;
    @(negedge clk);
    in_valid = 1'b1; alu_cont = 5'b00011; a = 16'h7FFF; b = 16'h0001;
    psr_load = 1'b1; psr_in = 16'hFFFF;
    @(negedge clk);
    in_valid = 1'b0; psr_load = 1'b0;
    vectors++;
    if (psr_flags !== 16'h00E5 || alu_out !== 16'h8000) begin
      miscompares++;
      $display("FAIL psr_win got %h out %h want 00e5 out 8000", psr_flags, alu_out);
    end
    psr_load = 1'b1; psr_in = 16'h0000;
    @(negedge clk);
    psr_load = 1'b0;
    vectors++;
    if (psr_flags !== 16'h0000) begin
      miscompares++;
      $display("FAIL psr_clr got %h want 0000", psr_flags);
    end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul;
    int busy_bad;
    busy_bad = 0;
    issue(5'b01100, 16'h0102, 16'h0003);
    for (int i = 0; i < 16; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
      @(negedge clk);
    end
    vectors++;
    if (busy_bad != 0) begin
      miscompares++;
      $display("FAIL mul_busy got %0d bad cycles want 0", busy_bad);
    end
    vectors++;
    if (out_valid !== 1'b1 || alu_out !== 16'h0306 || psr_flags !== 16'h0000) begin
      miscompares++;
      $display("FAIL mul_small got %h v=%b psr %h want 0306 v=1 psr 0000", alu_out, out_valid, psr_flags);
    end
    issue(5'b01100, 16'h0100, 16'h0100);
    repeat (16) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || alu_out !== 16'h0000 || psr_flags !== 16'h0021) begin
      miscompares++;
      $display("FAIL mul_ovf got %h v=%b psr %h want 0000 v=1 psr 0021", alu_out, out_valid, psr_flags);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    issue(5'b01100, 16'h0102, 16'h0003);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (alu_out !== 16'h0000 || psr_flags !== 16'h0000 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid got %h psr %h r=%b want 0000 psr 0000 r=1", alu_out, psr_flags, in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL rst_mid_valid got %0d pulses want 0", seen);
    end
  endtask
`else
  task automatic test_mul;
    issue(5'b01100, 16'h0102, 16'h0003);
    vectors++;
    if (alu_out !== 16'h0000 || out_valid !== 1'b1 || in_ready !== 1'b1 || psr_flags !== 16'h0000) begin
      miscompares++;
      $display("FAIL mul_illegal got %h v=%b r=%b psr %h want 0000 v=1 r=1 psr 0000",
               alu_out, out_valid, in_ready, psr_flags);
    end
  endtask

  task automatic test_reset_mid;
    issue(5'b00110, 16'h0000, 16'h5A5A);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (alu_out !== 16'h0000 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid got %h v=%b r=%b want 0000 v=0 r=1", alu_out, out_valid, in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_cmp;
    test_shift;
    test_misc_ops;
    test_back_to_back;
    test_psr;
    test_mul;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
